// File: rtl/slave_b_channel_fsm.sv
// AXI slave write-response (B) stage: buffers internal write responses in a small FIFO
// and presents them on the external B channel with a registered VALID/READY handshake.
module slave_b_channel_fsm #(
   parameter int unsigned B_FIFO_DEPTH = 4,
   localparam int unsigned ID_WIDTH = 4,
   localparam int unsigned AW = $clog2(B_FIFO_DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic [ID_WIDTH-1:0] int_resp_BID,
   input  logic [1:0]          int_resp_BRESP,
   input  logic                int_resp_BVALID,
   output logic [ID_WIDTH-1:0] BID,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   output logic [CW-1:0]       b_fifo_count,
   output logic                b_overflow
);

   typedef enum logic [1:0] {
      BIdle  = 2'b00,
      BValid = 2'b01
   } state_e;

   state_e                  state_q;
   logic [ID_WIDTH+1:0]     mem_q [B_FIFO_DEPTH];
   logic [AW:0]             wr_ptr_q, rd_ptr_q;
   logic                    empty, full, pop, push_ok;
   logic [ID_WIDTH+1:0]     head;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign b_fifo_count = wr_ptr_q - rd_ptr_q;
   assign head         = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      pop = 1'b0;
      case (state_q)
         BIdle:   pop = !empty;
         BValid:  pop = BREADY && !empty;
         default: pop = 1'b0;
      endcase
   end

   // A push into a full FIFO is still accepted when the head leaves at the same edge.
   assign push_ok = int_resp_BVALID && (!full || pop);

   always_ff @(posedge ACLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {int_resp_BID, int_resp_BRESP};
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= BIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         BID        <= '0;
         BRESP      <= 2'b00;
         BVALID     <= 1'b0;
         b_overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
         if (int_resp_BVALID && full && !pop) begin
            b_overflow <= 1'b1;
         end
         case (state_q)
            BIdle: begin
               if (!empty) begin
                  BID     <= head[ID_WIDTH+1:2];
                  BRESP   <= head[1:0];
                  BVALID  <= 1'b1;
                  state_q <= BValid;
               end
            end
            BValid: begin
               if (BREADY) begin
                  if (!empty) begin
                     BID   <= head[ID_WIDTH+1:2];
                     BRESP <= head[1:0];
                  end else begin
                     BVALID  <= 1'b0;
                     state_q <= BIdle;
                  end
               end
            end
            default: begin
               BVALID  <= 1'b0;
               state_q <= BIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slave_b_channel_fsm.sv
// Directed bench for slave_b_channel_fsm: single response, backpressure, overflow,
// push-at-full with pop, mixed response codes and asynchronous reset.
module tb_slave_b_channel_fsm;

   logic       ACLK = 1'b0;
   logic       ARESETn;
   logic [3:0] int_resp_BID;
   logic [1:0] int_resp_BRESP;
   logic       int_resp_BVALID;
   logic [3:0] BID;
   logic [1:0] BRESP;
   logic       BVALID;
   logic       BREADY;
   logic [2:0] b_fifo_count;
   logic       b_overflow;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 ACLK = ~ACLK;

   slave_b_channel_fsm #(.B_FIFO_DEPTH(4)) dut (
      .ACLK            (ACLK),
      .ARESETn         (ARESETn),
      .int_resp_BID    (int_resp_BID),
      .int_resp_BRESP  (int_resp_BRESP),
      .int_resp_BVALID (int_resp_BVALID),
      .BID             (BID),
      .BRESP           (BRESP),
      .BVALID          (BVALID),
      .BREADY          (BREADY),
      .b_fifo_count    (b_fifo_count),
      .b_overflow      (b_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [3:0] id, input logic [1:0] resp);
      int_resp_BID    = id;
      int_resp_BRESP  = resp;
      int_resp_BVALID = 1'b1;
      tick();
      int_resp_BVALID = 1'b0;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      #12;
      tick();
      ARESETn = 1'b1;
      tick();
   endtask

   initial begin
      ARESETn = 1'b0; int_resp_BID = '0; int_resp_BRESP = '0; int_resp_BVALID = 1'b0;
      BREADY = 1'b0;
      #3;
      chk("rst_bvalid", BVALID, 0);
      chk("rst_count", b_fifo_count, 0);
      chk("rst_ovf", b_overflow, 0);
      chk("rst_bid", BID, 0);
      chk("rst_bresp", BRESP, 0);
      do_reset();

      // Single response
      BREADY = 1'b1;
      push(4'd3, 2'b00);
      chk("single_cnt_after_push", b_fifo_count, 1);
      chk("single_bvalid_n", BVALID, 0);
      tick();
      chk("single_bvalid_n1", BVALID, 1);
      chk("single_bid_n1", BID, 3);
      chk("single_cnt_n1", b_fifo_count, 0);
      tick();
      chk("single_bvalid_n2", BVALID, 0);
      chk("single_cnt_n2", b_fifo_count, 0);

      // Backpressure
      BREADY = 1'b0;
      push(4'd1, 2'b00);
      push(4'd2, 2'b00);
      push(4'd3, 2'b00);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_bid", BID, 1);
         chk("bp_hold_bvalid", BVALID, 1);
         tick();
      end
      chk("bp_count", b_fifo_count, 2);
      BREADY = 1'b1;
      tick();
      chk("bp_drain_bid2", BID, 2);
      chk("bp_drain_v2", BVALID, 1);
      tick();
      chk("bp_drain_bid3", BID, 3);
      chk("bp_drain_v3", BVALID, 1);
      tick();
      chk("bp_drain_done", BVALID, 0);

      // Overflow
      BREADY = 1'b0;
      for (int i = 0; i < 6; i++) push(4'(i), 2'b00);
      chk("ovf_bid0", BID, 0);
      chk("ovf_count", b_fifo_count, 4);
      chk("ovf_flag", b_overflow, 1);
      BREADY = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("ovf_drain_bid", BID, i);
         chk("ovf_drain_v", BVALID, 1);
      end
      tick();
      chk("ovf_drain_done", BVALID, 0);
      chk("ovf_sticky", b_overflow, 1);
      BREADY = 1'b0;
      do_reset();
      chk("ovf_cleared", b_overflow, 0);

      // Push at full with simultaneous pop
      for (int i = 1; i <= 5; i++) push(4'(i), 2'b00);
      chk("full_count", b_fifo_count, 4);
      chk("full_bid", BID, 1);
      BREADY = 1'b1;
      push(4'd7, 2'b00);
      chk("fullpop_count", b_fifo_count, 4);
      chk("fullpop_ovf", b_overflow, 0);
      chk("fullpop_bid", BID, 2);
      tick(); chk("fullpop_d3", BID, 3);
      tick(); chk("fullpop_d4", BID, 4);
      tick(); chk("fullpop_d5", BID, 5);
      tick(); chk("fullpop_d7", BID, 7);
      chk("fullpop_v7", BVALID, 1);
      tick();
      chk("fullpop_done", BVALID, 0);

      // Mixed response codes: SLVERR=2, DECERR=3, EXOKAY=1
      BREADY = 1'b0;
      push(4'd2, 2'b10);
      push(4'd9, 2'b11);
      push(4'd4, 2'b01);
      chk("mix_bid0", BID, 2);
      chk("mix_resp0", BRESP, 2'b10);
      BREADY = 1'b1;
      tick();
      chk("mix_bid1", BID, 9);
      chk("mix_resp1", BRESP, 2'b11);
      tick();
      chk("mix_bid2", BID, 4);
      chk("mix_resp2", BRESP, 2'b01);
      tick();
      chk("mix_done", BVALID, 0);

      // Asynchronous reset mid-operation
      BREADY = 1'b0;
      for (int i = 1; i <= 4; i++) push(4'(i), 2'b00);
      chk("arst_pre_v", BVALID, 1);
      chk("arst_pre_cnt", b_fifo_count, 3);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("arst_bvalid", BVALID, 0);
      chk("arst_count", b_fifo_count, 0);
      chk("arst_ovf", b_overflow, 0);
      #1;
      ARESETn = 1'b1;
      tick();
      tick();
      chk("arst_idle_v", BVALID, 0);
      chk("arst_idle_cnt", b_fifo_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
